forward_stall_unit: RTL
=======================

FORWARD_STALL_UNIT -- requirements
Module: forward_stall_unit

Interface
REQ-001 Parameter ADDR_W, default 5: register address width.
REQ-002 Parameter N_SRC, default 3: source operands per instruction (channels).
REQ-003 Parameter MUL_LAT, default 4, legal range 2..15: cycles from multicycle issue in EX to result write.
REQ-004 clk  in  1: single clock; all state updates on rising edge.
REQ-005 rst  in  1: reset, synchronous and active-high.
REQ-006 regfile_en_MEM, regfile_en_WB  in  1 each: write enables of the MEM and WB stages.
REQ-007 write_addr_MEM, write_addr_WB, write_addr_EX  in  ADDR_W each: destination registers.
REQ-008 src_addr_EX, src_addr_ID  in  N_SRC*ADDR_W each: packed sources; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 mem_read_EX  in  1: a load is in EX.
REQ-010 mul_issue_EX  in  1: a multicycle op is in EX this cycle; mul_dest  in  ADDR_W: its destination.
REQ-011 mul_req_ID  in  1: the instruction in ID is a multicycle op.
REQ-012 forward  out  2*N_SRC: forward select per channel, bits [2i+1:2i].
REQ-013 stall_IF_ID  out  1: hold PC and the IF/ID register; flush_EX  out  1: insert a bubble into ID/EX.
REQ-014 mul_busy  out  1; mul_wb  out  1: the multicycle result is written this cycle; protocol_err  out  1: sticky.

Function
REQ-015 Forwarding is combinational per channel i: 2'b10 if regfile_en_MEM, write_addr_MEM==src_i and src_i!=0; else 2'b01 if regfile_en_WB, write_addr_WB==src_i and src_i!=0; else 2'b00.
REQ-016 MEM has priority over WB when both match the same channel; address 0 is never forwarded.
REQ-017 Load-use hazard (combinational): mem_read_EX and write_addr_EX!=0 and write_addr_EX equals any src_addr_ID channel.
REQ-018 States: IDLE (cnt==0) and BUSY (cnt!=0); cnt is a 4-bit down-counter; pend_dest is an ADDR_W register.
REQ-019 In IDLE, mul_issue_EX loads cnt=MUL_LAT and pend_dest=mul_dest and enters BUSY next cycle, including when mul_dest==0.
REQ-020 In BUSY, cnt decrements by 1 each cycle; the 1->0 transition returns the block to IDLE.
REQ-021 mul_wb = 1 exactly while cnt==1, giving one pulse per issue, MUL_LAT cycles after the issue cycle; mul_busy = (cnt!=0).
REQ-022 RAW on pending result: BUSY and cnt>1 and pend_dest!=0 and any src_addr_ID channel equals pend_dest; released at cnt==1, since the register file is write-before-read.
REQ-023 Structural hazard: mul_req_ID and BUSY and cnt>1; released at cnt==1, so the held op reaches EX only in IDLE.
REQ-024 stall_IF_ID = flush_EX = OR of REQ-017, REQ-022 and REQ-023, and are asserted in the same cycle as the hazard.
REQ-025 mul_issue_EX while BUSY is ignored: cnt and pend_dest are unchanged and protocol_err is set to 1 the next cycle, holding until reset.
REQ-026 Forwarding outputs are independent of stall state and are never gated by stall_IF_ID.
REQ-027 There is no combinational path from stall_IF_ID or flush_EX back into any input-derived state.

Reset
REQ-028 While rst=1 at a clock edge, the next state is cnt=0, pend_dest=0, protocol_err=0; rst has priority over mul_issue_EX in the same cycle.
REQ-029 After reset: mul_busy=0, mul_wb=0; stall_IF_ID, flush_EX and forward follow only their combinational inputs.
REQ-030 A reset asserted while BUSY aborts the pending op, and no mul_wb pulse follows.

Verification
REQ-031 Channel 1 src_addr_EX=5, write_addr_MEM=5, write_addr_WB=5, both enables 1 -> forward[3:2]=2'b10; set regfile_en_MEM=0 -> 2'b01; set src=0 -> 2'b00.
REQ-032 mem_read_EX=1, write_addr_EX=7, src_addr_ID channel 2 = 7 -> stall_IF_ID=flush_EX=1 for that cycle only; with write_addr_EX=0 -> no stall.
REQ-033 MUL_LAT=4: issue with mul_dest=9 at cycle t -> mul_busy=1 at t+1..t+4; mul_wb=1 only at t+4; a src_addr_ID of 9 is stalled at t+1..t+3 and released at t+4.
REQ-034 mul_req_ID=1 held while BUSY -> stall at cnt 4,3,2; no stall at cnt 1; re-issue at the next cycle is accepted and protocol_err remains 0.
REQ-035 Second mul_issue_EX at cnt=3 -> cnt continues 2,1,0, pend_dest is unchanged and protocol_err=1 until rst.
REQ-036 rst=1 at cnt=2 -> cnt=0 and mul_busy=0 next cycle, no mul_wb pulse, and protocol_err cleared.

Source files
------------

// File: rtl/forward_stall_unit.sv
// Operand forwarding and pipeline hazard detection for a five-stage pipeline.
// It also tracks one multicycle unit whose result is written MUL_LAT cycles after issue.
module forward_stall_unit #(
  parameter int ADDR_W  = 5,
  parameter int N_SRC   = 3,
  parameter int MUL_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    regfile_en_MEM,
  input  logic                    regfile_en_WB,
  input  logic [ADDR_W-1:0]       write_addr_MEM,
  input  logic [ADDR_W-1:0]       write_addr_WB,
  input  logic [ADDR_W-1:0]       write_addr_EX,
  input  logic [N_SRC*ADDR_W-1:0] src_addr_EX,
  input  logic [N_SRC*ADDR_W-1:0] src_addr_ID,
  input  logic                    mem_read_EX,
  input  logic                    mul_issue_EX,
  input  logic [ADDR_W-1:0]       mul_dest,
  input  logic                    mul_req_ID,
  output logic [2*N_SRC-1:0]      forward,
  output logic                    stall_IF_ID,
  output logic                    flush_EX,
  output logic                    mul_busy,
  output logic                    mul_wb,
  output logic                    protocol_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] LAT = 4'(MUL_LAT);

  state_t            state;
  logic [3:0]        cnt, cnt_next;
  logic [ADDR_W-1:0] pend_dest, pend_next;
  logic              err_next;
  logic [N_SRC-1:0]  lu_hit, pend_hit;
  logic              load_use, raw_pend, struct_haz;

  for (genvar i = 0; i < N_SRC; i++) begin : g_ch
    logic [ADDR_W-1:0] s_ex, s_id;
    assign s_ex = src_addr_EX[i*ADDR_W +: ADDR_W];
    assign s_id = src_addr_ID[i*ADDR_W +: ADDR_W];

    // MEM holds the younger result, so it wins over WB; r0 is hardwired zero.
    assign forward[2*i +: 2] =
      (regfile_en_MEM && write_addr_MEM == s_ex && s_ex != '0) ? 2'b10 :
      (regfile_en_WB  && write_addr_WB  == s_ex && s_ex != '0) ? 2'b01 : 2'b00;

    assign lu_hit[i]   = (s_id == write_addr_EX);
    assign pend_hit[i] = (s_id == pend_dest);
  end

  assign load_use = mem_read_EX && (write_addr_EX != '0) && (|lu_hit);

  // At cnt==1 the result is written this cycle and the register file is
  // write-before-read, so neither hazard needs to hold ID any longer.
  assign raw_pend   = (state == BUSY) && (cnt > 4'd1) && (pend_dest != '0) && (|pend_hit);
  assign struct_haz = mul_req_ID && (state == BUSY) && (cnt > 4'd1);

  assign stall_IF_ID = load_use || raw_pend || struct_haz;
  assign flush_EX    = stall_IF_ID;

  assign mul_busy = (state == BUSY);
  assign mul_wb   = (cnt == 4'd1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_next  = cnt;
    pend_next = pend_dest;
    err_next  = protocol_err;
    state     = (cnt == 4'd0) ? IDLE : BUSY;
    case (state)
      IDLE: begin
        if (mul_issue_EX) begin
          cnt_next  = LAT;
          pend_next = mul_dest;
        end
      end
      BUSY: begin
        cnt_next = cnt - 4'd1;
        // A second issue while busy is dropped and flagged until reset.
        if (mul_issue_EX) err_next = 1'b1;
      end
      default: cnt_next = 4'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 4'd0;
      pend_dest    <= '0;
      protocol_err <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      pend_dest    <= pend_next;
      protocol_err <= err_next;
    end
  end

endmodule
